fetch_ctrl: RTL and testbench

- PC sequencing controller for the 5-stage uP16 pipeline. Drives the fetch stage's PC-select mux (sel_PC/alt_PC) and the IF/ID and ID/EX pipeline-register control.
- Arbitrates between three sources: EX-stage branch redirects, ID-stage jumps and load-use stalls. Stalls hold the PC by re-selecting the current PC.
- Keeps saturating performance counters and a stall watchdog.

---
 rtl/fetch_ctrl_if.sv | 58 +++++
 rtl/fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Fetch-control bus of the uP16 pipeline. It carries the redirect,
//               jump and stall requests, the PC-select and pipeline-register
//               controls, and the status counters. The IRQ signals are present
//               only when FETCH_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int DSIZE = 16,
    parameter int CSIZE = 16
);
    logic [DSIZE-1:0] currPC;
    logic             ex_br_taken;
    logic [DSIZE-1:0] ex_br_target;
    logic             id_jmp;
    logic [DSIZE-1:0] id_jmp_target;
    logic             ld_use_stall;
    logic             sel_PC;
    logic [DSIZE-1:0] alt_PC;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic             stall_IF_ID;
    logic [1:0]       ctrl_state;
    logic [CSIZE-1:0] br_cnt;
    logic [CSIZE-1:0] stall_cnt;
    logic             stall_err;
`ifdef FETCH_IRQ_EN
    logic             irq;
    logic             irq_ret;
    logic             irq_ack;
    logic [DSIZE-1:0] epc;
`endif

    // The controller side.
    modport slave (
        input  currPC, ex_br_taken, ex_br_target, id_jmp, id_jmp_target, ld_use_stall,
`ifdef FETCH_IRQ_EN
        input  irq, irq_ret,
        output irq_ack, epc,
`endif
        output sel_PC, alt_PC, flush_IF_ID, flush_ID_EX, stall_IF_ID,
        output ctrl_state, br_cnt, stall_cnt, stall_err
    );

    // The pipeline side.
    modport master (
        output currPC, ex_br_taken, ex_br_target, id_jmp, id_jmp_target, ld_use_stall,
`ifdef FETCH_IRQ_EN
        output irq, irq_ret,
        input  irq_ack, epc,
`endif
        input  sel_PC, alt_PC, flush_IF_ID, flush_ID_EX, stall_IF_ID,
        input  ctrl_state, br_cnt, stall_cnt, stall_err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : PC sequencing controller for the uP16 pipeline. It handles
//               branch and jump redirects and load-use holds, and keeps
//               saturating counters and a stall watchdog.
//               The optional interrupt entry is enabled by defining FETCH_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int DSIZE     = 16,
    parameter int CSIZE     = 16,
    parameter int MAX_STALL = 8
`ifdef FETCH_IRQ_EN
    ,
    parameter logic [DSIZE-1:0] IRQ_VEC = DSIZE'('h0010)
`endif
) (
    input  wire logic   Clk,
    input  wire logic   Rst,
    fetch_ctrl_if.slave bus
);
    localparam logic [1:0] c_BOOT  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_REDIR = 2'd3;

    localparam int               c_RUN_W     = 8;
    localparam logic [c_RUN_W-1:0] c_MAX_STALL = c_RUN_W'(MAX_STALL);

    logic [1:0]         r_state;
    logic               r_rst_meta;
    logic [CSIZE-1:0]   r_br_cnt;
    logic [CSIZE-1:0]   r_stall_cnt;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic               r_stall_err;

    logic [1:0]         w_nxt_state;
    logic               w_sel_pc;
    logic [DSIZE-1:0]   w_alt_pc;
    logic               w_flush_if_id;
    logic               w_flush_id_ex;
    logic               w_stall_if_id;
    logic               w_br_evt;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic               w_irq_take;

`ifdef FETCH_IRQ_EN
    logic             r_mask;
    logic [DSIZE-1:0] r_epc;
`endif

    always_comb begin
        w_nxt_state   = r_state;
        w_sel_pc      = 1'b0;
        w_alt_pc      = bus.currPC;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_stall_if_id = 1'b0;
        w_br_evt      = 1'b0;
        w_irq_take    = 1'b0;
        case (r_state)
            c_BOOT: begin
                w_alt_pc      = '0;
                w_flush_if_id = 1'b1;
                w_nxt_state   = r_rst_meta ? c_RUN : c_BOOT;
            end
            c_RUN, c_HOLD: begin
                if (bus.ex_br_taken) begin
                    w_sel_pc      = 1'b1;
                    w_alt_pc      = bus.ex_br_target;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_br_evt      = 1'b1;
                    w_nxt_state   = c_REDIR;
                end else if (bus.id_jmp) begin
                    w_sel_pc      = 1'b1;
                    w_alt_pc      = bus.id_jmp_target;
                    w_flush_if_id = 1'b1;
                    w_br_evt      = 1'b1;
                    w_nxt_state   = c_REDIR;
                end else if (bus.ld_use_stall) begin
                    // Re-select the current PC so that fetch and the I-memory address hold still.
                    w_sel_pc      = 1'b1;
                    w_stall_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_nxt_state   = c_HOLD;
                end else begin
                    w_nxt_state   = c_RUN;
`ifdef FETCH_IRQ_EN
                    if ((r_state == c_RUN) && bus.irq && !r_mask) begin
                        w_irq_take    = 1'b1;
                        w_sel_pc      = 1'b1;
                        w_alt_pc      = IRQ_VEC;
                        w_flush_if_id = 1'b1;
                        w_nxt_state   = c_REDIR;
                    end
`endif
                end
            end
            default: begin
                // REDIR: ID and EX hold bubbles, so only a new EX branch matters.
                if (bus.ex_br_taken) begin
                    w_sel_pc      = 1'b1;
                    w_alt_pc      = bus.ex_br_target;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_br_evt      = 1'b1;
                    w_nxt_state   = c_REDIR;
                end else begin
                    w_nxt_state   = c_RUN;
                end
            end
        endcase
    end

    assign w_run_nxt = !w_stall_if_id      ? '0 :
                       (r_run_cnt == '1)   ? r_run_cnt :
                                             r_run_cnt + c_RUN_W'(1);

    // r_rst_meta is the first stage of the reset-release chain; r_state leaving BOOT is the second.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rst_meta  <= 1'b0;
            r_state     <= c_BOOT;
            r_br_cnt    <= '0;
            r_stall_cnt <= '0;
            r_run_cnt   <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_state    <= w_nxt_state;
            r_run_cnt  <= w_run_nxt;
            if (w_br_evt && (r_br_cnt != '1))
                r_br_cnt <= r_br_cnt + CSIZE'(1);
            if (w_stall_if_id && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CSIZE'(1);
            if (w_run_nxt >= c_MAX_STALL)
                r_stall_err <= 1'b1;
        end
    end

`ifdef FETCH_IRQ_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_mask <= 1'b0;
            r_epc  <= '0;
        end else begin
            if (w_irq_take) begin
                r_mask <= 1'b1;
                r_epc  <= bus.currPC;
            end else if (bus.irq_ret) begin
                r_mask <= 1'b0;
            end
        end
    end

    assign bus.irq_ack = w_irq_take;
    assign bus.epc     = r_epc;
`endif

    assign bus.sel_PC      = w_sel_pc;
    assign bus.alt_PC      = w_alt_pc;
    assign bus.flush_IF_ID = w_flush_if_id;
    assign bus.flush_ID_EX = w_flush_id_ex;
    assign bus.stall_IF_ID = w_stall_if_id;
    assign bus.ctrl_state  = r_state;
    assign bus.br_cnt      = r_br_cnt;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.stall_err   = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl. A second instance
//               with CSIZE=4 is used to check counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_fail;

    fetch_ctrl_if #(.DSIZE(16), .CSIZE(16)) bus ();
    fetch_ctrl_if #(.DSIZE(16), .CSIZE(4))  bus_s ();

    fetch_ctrl #(.DSIZE(16), .CSIZE(16), .MAX_STALL(8)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    fetch_ctrl #(.DSIZE(16), .CSIZE(4), .MAX_STALL(8)) u_dut_sat (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_s.slave)
    );

    assign bus_s.currPC        = bus.currPC;
    assign bus_s.ex_br_taken   = bus.ex_br_taken;
    assign bus_s.ex_br_target  = bus.ex_br_target;
    assign bus_s.id_jmp        = bus.id_jmp;
    assign bus_s.id_jmp_target = bus.id_jmp_target;
    assign bus_s.ld_use_stall  = bus.ld_use_stall;
`ifdef FETCH_IRQ_EN
    assign bus_s.irq           = bus.irq;
    assign bus_s.irq_ret       = bus.irq_ret;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Rst                = 1'b0;
        bus.currPC         = 16'h0100;
        bus.ex_br_taken    = 1'b0;
        bus.ex_br_target   = 16'h0000;
        bus.id_jmp         = 1'b0;
        bus.id_jmp_target  = 16'h0000;
        bus.ld_use_stall   = 1'b0;
`ifdef FETCH_IRQ_EN
        bus.irq            = 1'b0;
        bus.irq_ret        = 1'b0;
`endif

        // Reset
        repeat (3) step();
        chk("rst_state", 32'(bus.ctrl_state), 32'd0);
        chk("rst_flush", 32'(bus.flush_IF_ID), 32'd1);
        chk("rst_alt",   32'(bus.alt_PC), 32'h0);
        chk("rst_sel",   32'(bus.sel_PC), 32'd0);
        chk("rst_brcnt", 32'(bus.br_cnt), 32'd0);
        chk("rst_stcnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_err",   32'(bus.stall_err), 32'd0);
        Rst = 1'b1;
        step();
        chk("boot_e1_state", 32'(bus.ctrl_state), 32'd0);
        chk("boot_e1_flush", 32'(bus.flush_IF_ID), 32'd1);
        step();
        chk("boot_e2_state", 32'(bus.ctrl_state), 32'd1);
        chk("run_flush",     32'(bus.flush_IF_ID), 32'd0);
        chk("run_alt",       32'(bus.alt_PC), 32'h0100);
        chk("run_sel",       32'(bus.sel_PC), 32'd0);

        // Taken branch
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 16'h0040;
        settle();
        chk("br_sel",    32'(bus.sel_PC), 32'd1);
        chk("br_alt",    32'(bus.alt_PC), 32'h0040);
        chk("br_fifid",  32'(bus.flush_IF_ID), 32'd1);
        chk("br_fidex",  32'(bus.flush_ID_EX), 32'd1);
        step();
        bus.ex_br_taken = 1'b0;
        chk("br_state",  32'(bus.ctrl_state), 32'd3);
        chk("br_cnt1",   32'(bus.br_cnt), 32'd1);
        step();
        chk("br_back",   32'(bus.ctrl_state), 32'd1);

        // Simultaneous events: branch wins
        bus.ex_br_taken   = 1'b1;
        bus.ex_br_target  = 16'h0080;
        bus.id_jmp        = 1'b1;
        bus.id_jmp_target = 16'h0020;
        bus.ld_use_stall  = 1'b1;
        settle();
        chk("sim_alt",   32'(bus.alt_PC), 32'h0080);
        chk("sim_stall", 32'(bus.stall_IF_ID), 32'd0);
        step();
        bus.ex_br_taken  = 1'b0;
        bus.id_jmp       = 1'b0;
        bus.ld_use_stall = 1'b0;
        chk("sim_brcnt", 32'(bus.br_cnt), 32'd2);
        chk("sim_stcnt", 32'(bus.stall_cnt), 32'd0);
        step();

        // Load-use stall for two cycles
        bus.currPC       = 16'h0005;
        bus.ld_use_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("ld_alt",   32'(bus.alt_PC), 32'h0005);
            chk("ld_sel",   32'(bus.sel_PC), 32'd1);
            chk("ld_stall", 32'(bus.stall_IF_ID), 32'd1);
            chk("ld_fidex", 32'(bus.flush_ID_EX), 32'd1);
            step();
            chk("ld_state", 32'(bus.ctrl_state), 32'd2);
        end
        bus.ld_use_stall = 1'b0;
        settle();
        chk("ld_stcnt",   32'(bus.stall_cnt), 32'd2);
        chk("ld_release", 32'(bus.stall_IF_ID), 32'd0);
        step();
        chk("ld_run",     32'(bus.ctrl_state), 32'd1);

        // Jump; id_jmp still high during REDIR is ignored
        bus.id_jmp        = 1'b1;
        bus.id_jmp_target = 16'h0030;
        settle();
        chk("jmp_alt",   32'(bus.alt_PC), 32'h0030);
        chk("jmp_fidex", 32'(bus.flush_ID_EX), 32'd0);
        step();
        settle();
        chk("redir_ign_sel", 32'(bus.sel_PC), 32'd0);
        chk("redir_ign_alt", 32'(bus.alt_PC), 32'h0005);
        step();
        bus.id_jmp = 1'b0;
        chk("jmp_run",   32'(bus.ctrl_state), 32'd1);
        chk("jmp_brcnt", 32'(bus.br_cnt), 32'd3);

        // Branch arriving in HOLD wins over the stall
        bus.ld_use_stall = 1'b1;
        step();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 16'h0200;
        settle();
        chk("hold_br_stall", 32'(bus.stall_IF_ID), 32'd0);
        chk("hold_br_flush", 32'(bus.flush_IF_ID), 32'd1);
        chk("hold_br_alt",   32'(bus.alt_PC), 32'h0200);
        step();
        bus.ex_br_taken  = 1'b0;
        bus.ld_use_stall = 1'b0;
        chk("hold_br_state", 32'(bus.ctrl_state), 32'd3);
        chk("hold_br_stcnt", 32'(bus.stall_cnt), 32'd3);
        chk("hold_br_brcnt", 32'(bus.br_cnt), 32'd4);
        step();

        // Watchdog: 8 consecutive stall cycles
        bus.ld_use_stall = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("wd_before", 32'(bus.stall_err), 32'd0);
        step();
        chk("wd_set",    32'(bus.stall_err), 32'd1);
        chk("wd_stcnt",  32'(bus.stall_cnt), 32'd11);
        bus.ld_use_stall = 1'b0;
        step();
        step();
        chk("wd_sticky", 32'(bus.stall_err), 32'd1);
        chk("wd_run",    32'(bus.ctrl_state), 32'd1);

        // Saturation: 20 back-to-back redirects
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 16'h0300;
        for (int i = 0; i < 20; i++) step();
        bus.ex_br_taken = 1'b0;
        chk("sat_brcnt4",  32'(bus_s.br_cnt), 32'd15);
        chk("sat_brcnt16", 32'(bus.br_cnt), 32'd24);
        step();
        chk("sat_run", 32'(bus.ctrl_state), 32'd1);

`ifdef FETCH_IRQ_EN
        // Interrupt entry, masking and return
        bus.currPC = 16'h0012;
        bus.irq    = 1'b1;
        settle();
        chk("irq_sel",   32'(bus.sel_PC), 32'd1);
        chk("irq_alt",   32'(bus.alt_PC), 32'h0010);
        chk("irq_ack",   32'(bus.irq_ack), 32'd1);
        chk("irq_flush", 32'(bus.flush_IF_ID), 32'd1);
        step();
        chk("irq_state", 32'(bus.ctrl_state), 32'd3);
        chk("irq_epc",   32'(bus.epc), 32'h0012);
        chk("irq_ack_redir", 32'(bus.irq_ack), 32'd0);
        step();
        chk("irq_masked_ack", 32'(bus.irq_ack), 32'd0);
        chk("irq_masked_sel", 32'(bus.sel_PC), 32'd0);
        bus.irq_ret = 1'b1;
        step();
        bus.irq_ret = 1'b0;
        settle();
        chk("irq_retaken", 32'(bus.irq_ack), 32'd1);
        bus.irq = 1'b0;
        step();
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
